elevator_scheduler: RTL and testbench
=====================================

// Module: elevator_scheduler
// PURPOSE
//  Call scheduler and motion sequencer for a multi-floor elevator car.
//  - Latches hall calls from every floor and picks the next target with a SCAN policy:
//    keep the current direction while calls remain ahead.
//  - Drives floor position, door and motion outputs using fixed per-floor travel time and door dwell time.
//  - Sits between the board switches (call inputs) and the LED/SEG outputs in top.
// PARAMETERS
//  NFLOORS     4  number of floors, floor 0 = ground; >= 2
//  TRAVEL_CYC  2  clock cycles to travel one floor; >= 1
//  DOOR_CYC    2  clock cycles the door stays open per stop; >= 1
// PORTS
//  clk_2    in   1                  system clock; all state updates on its rising edge
//  reset    in   1                  synchronous reset, active-low (0 = reset)
//  call     in   NFLOORS            call[i]=1 at a rising edge registers one request for floor i
//  floor    out  $clog2(NFLOORS)    current car floor
//  porta    out  1                  door open
//  moving   out  1                  car in motion between floors
//  dir_up   out  1                  current SCAN direction (1 = up)
//  pending  out  NFLOORS            latched, not-yet-served calls
// BEHAVIOUR
//  Reset (reset==0 at an edge, any state, including mid-travel):
//  - state=DOOR_OPEN, floor=0, porta=1, moving=0, dir_up=1, pending=0.
//  - door timer=DOOR_CYC, travel timer=0.
//  - The car is placed at floor 0 immediately; there is no return trip.
//  Call latching, every edge: pending <= pending | call, except the following cases.
//  - DOOR_OPEN, call[floor]=1: bit is not latched; door timer reloads to DOOR_CYC (dwell extension).
//  - IDLE, call[floor]=1: bit is not latched; next state is DOOR_OPEN, door timer=DOOR_CYC.
//  - MOVING, call[floor]=1: latched. floor is the floor being left, so the call is served later.
//  States:
//  - IDLE (porta=0, moving=0):
//    - pending==0: stay in IDLE.
//    - pending!=0: go to MOVING with direction chosen as below; travel timer=TRAVEL_CYC.
//  - DOOR_OPEN (porta=1, moving=0):
//    - Timer decrements each cycle. When it reads 1 and there is no extension:
//      pending==0 -> IDLE; else -> MOVING with direction chosen.
//    - Door is open exactly DOOR_CYC cycles absent extensions.
//  - MOVING (porta=0, moving=1):
//    - Travel timer decrements. When it reads 1, floor steps +1 if dir_up, else -1.
//    - If pending[new floor]=1, or call[new floor]=1 on that edge: clear that bit, go to DOOR_OPEN,
//      door timer=DOOR_CYC.
//    - Otherwise stay in MOVING, timer=TRAVEL_CYC.
//  Direction choice (SCAN), with above = |pending[NFLOORS-1:floor+1] and below = |pending[floor-1:0]:
//  - dir_up=1: above -> up; else below -> down.
//  - dir_up=0: below -> down; else above -> up.
//  - dir_up updates only on a reversal. The car never leaves range 0..NFLOORS-1
//    (a target always exists in the chosen direction).
//  Latency: call for floor f!=floor in IDLE at edge k -> pending[f]=1 after k,
//    moving=1 after k+1, floor changes at k+1+TRAVEL_CYC.
//  Widths: timers are $clog2(max(TRAVEL_CYC,DOOR_CYC))+1 bits unsigned; floor arithmetic never wraps.
// STRUCTURE
//  Package elevator_pkg:
//  - state_e enum {IDLE, DOOR_OPEN, MOVING}
//  - floor_t = logic [$clog2(NFLOORS)-1:0]
//  - default parameter constants
//  Sub-module call_latch:
//  - pending register with set and clear-one inputs
//  - combinational above/below reduction for a given floor
//  FSM, timers and direction logic stay in elevator_scheduler.
// TESTING (NFLOORS=4, TRAVEL_CYC=2, DOOR_CYC=2)
//  1. Hold reset=0 one edge, then 1 -> floor=0, porta=1, pending=0;
//     after 2 edges porta=0, IDLE; remains IDLE with call=0.
//  2. IDLE at floor 0, call=4'b0100 for one edge:
//     pending=0100; next edge moving=1; floor=1 after 2 more edges, floor=2 after 2 more;
//     at that edge porta=1, pending=0000; door closes 2 edges later.
//  3. Moving up from floor 1 toward 3, call=4'b0001 issued:
//     car stops at 3 first, then dir_up=0, travels 3->0, opens at 0.
//  4. DOOR_OPEN at floor 2, call=4'b0100 on the edge the timer reads 1:
//     door stays open 2 more edges; pending[2] never set.
//  5. IDLE at floor 1, dir_up=1, call=4'b1001 on the same edge:
//     serves floor 3 first, then floor 0.
//  6. reset=0 while MOVING between floors 2 and 3 with pending=1001:
//     next edge floor=0, porta=1, moving=0, pending=0, dir_up=1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types, default sizing and the SCAN direction rule for the elevator scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DOOR_OPEN,
    MOVING
  } state_e;

  localparam int DEF_NFLOORS    = 4;
  localparam int DEF_TRAVEL_CYC = 2;
  localparam int DEF_DOOR_CYC   = 2;

  typedef logic [$clog2(DEF_NFLOORS)-1:0] floor_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Keep heading while calls remain ahead; reverse only when the other side has work.
  function automatic logic scan_dir(input logic dir_up, input logic above, input logic below);
    if (dir_up) return above | ~below;
    else        return above & ~below;
  endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Board-side bundle: call switches in, car position/door/motion status out.
interface elevator_scheduler_if #(
  parameter int NFLOORS = elevator_pkg::DEF_NFLOORS
);
  localparam int FW = $clog2(NFLOORS);

  logic [NFLOORS-1:0] call;
  logic [FW-1:0]      floor;
  logic               porta;
  logic               moving;
  logic               dir_up;
  logic [NFLOORS-1:0] pending;

  modport master (
    output call,
    input  floor, porta, moving, dir_up, pending
  );

  modport slave (
    input  call,
    output floor, porta, moving, dir_up, pending
  );
endinterface

// File: rtl/elevator_scheduler_call_latch.sv
// Pending hall-call register with set/clear-one update and above/below reduction.
module call_latch
  import elevator_pkg::*;
#(
  parameter int NFLOORS = DEF_NFLOORS
) (
  input  logic                       clk_2,
  input  logic                       reset,
  input  logic [NFLOORS-1:0]         set,
  input  logic                       clr_en,
  input  logic [$clog2(NFLOORS)-1:0] clr_idx,
  input  logic [$clog2(NFLOORS)-1:0] floor,
  output logic [NFLOORS-1:0]         pending,
  output logic                       above,
  output logic                       below
);

  logic [NFLOORS-1:0] clr_vec;

  always_comb begin
    clr_vec = '0;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
  end

  // NOTE: pending is a small flop vector, not a RAM, so it is reset explicitly
  // rather than relying on an initialisation pass.
  always_ff @(posedge clk_2) begin
    if (!reset) pending <= '0;
    else        pending <= (pending | set) & ~clr_vec;
  end

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (i > int'(floor)) above = above | pending[i];
      if (i < int'(floor)) below = below | pending[i];
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Elevator car sequencer: SCAN target selection, travel and door timing.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NFLOORS    = DEF_NFLOORS,
  parameter int TRAVEL_CYC = DEF_TRAVEL_CYC,
  parameter int DOOR_CYC   = DEF_DOOR_CYC
) (
  input logic                clk_2,
  input logic                reset,
  elevator_scheduler_if.slave bus
);

  localparam int FW = $clog2(NFLOORS);
  localparam int TW = $clog2(max_int(TRAVEL_CYC, DOOR_CYC)) + 1;

  state_e             state, state_n;
  logic [FW-1:0]      floor_q, floor_n, step;
  logic               dir_q, dir_n, dir_pick;
  logic [TW-1:0]      door_tmr, door_n, trav_tmr, trav_n;
  logic [NFLOORS-1:0] set_vec, pend;
  logic               clr_en;
  logic [FW-1:0]      clr_idx;
  logic               above, below;

  call_latch #(.NFLOORS(NFLOORS)) u_call_latch (
    .clk_2   (clk_2),
    .reset   (reset),
    .set     (set_vec),
    .clr_en  (clr_en),
    .clr_idx (clr_idx),
    .floor   (floor_q),
    .pending (pend),
    .above   (above),
    .below   (below)
  );

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    floor_n  = floor_q;
    dir_n    = dir_q;
    door_n   = door_tmr;
    trav_n   = trav_tmr;
    set_vec  = bus.call;
    clr_en   = 1'b0;
    clr_idx  = floor_q;
    dir_pick = scan_dir(dir_q, above, below);
    step     = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);

    unique case (state)
      IDLE: begin
        set_vec[floor_q] = 1'b0;
        if (bus.call[floor_q]) begin
          state_n = DOOR_OPEN;
          door_n  = TW'(DOOR_CYC);
        end else if (|pend) begin
          state_n = MOVING;
          dir_n   = dir_pick;
          trav_n  = TW'(TRAVEL_CYC);
        end
      end

      DOOR_OPEN: begin
        // A call at the open floor holds the door instead of queuing a revisit.
        set_vec[floor_q] = 1'b0;
        if (bus.call[floor_q]) begin
          door_n = TW'(DOOR_CYC);
        end else if (door_tmr == TW'(1)) begin
          if (|pend) begin
            state_n = MOVING;
            dir_n   = dir_pick;
            trav_n  = TW'(TRAVEL_CYC);
          end else begin
            state_n = IDLE;
          end
        end else begin
          door_n = door_tmr - TW'(1);
        end
      end

      MOVING: begin
        if (trav_tmr == TW'(1)) begin
          floor_n = step;
          if (pend[step] | bus.call[step]) begin
            clr_en  = 1'b1;
            clr_idx = step;
            state_n = DOOR_OPEN;
            door_n  = TW'(DOOR_CYC);
          end else begin
            trav_n = TW'(TRAVEL_CYC);
          end
        end else begin
          trav_n = trav_tmr - TW'(1);
        end
      end

      default: state_n = DOOR_OPEN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      state    <= DOOR_OPEN;
      floor_q  <= '0;
      dir_q    <= 1'b1;
      door_tmr <= TW'(DOOR_CYC);
      trav_tmr <= '0;
    end else begin
      state    <= state_n;
      floor_q  <= floor_n;
      dir_q    <= dir_n;
      door_tmr <= door_n;
      trav_tmr <= trav_n;
    end
  end

  assign bus.floor   = floor_q;
  assign bus.porta   = (state == DOOR_OPEN);
  assign bus.moving  = (state == MOVING);
  assign bus.dir_up  = dir_q;
  assign bus.pending = pend;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed scenarios plus random calls, checked cycle by cycle against a behavioural car model.
module tb_elevator_scheduler;
  import elevator_pkg::*;

  localparam int NF     = 4;
  localparam int TRAVEL = 2;
  localparam int DOOR   = 2;

  logic clk_2 = 1'b0;
  logic reset = 1'b0;

  elevator_scheduler_if #(.NFLOORS(NF)) bus();

  elevator_scheduler #(
    .NFLOORS    (NF),
    .TRAVEL_CYC (TRAVEL),
    .DOOR_CYC   (DOOR)
  ) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural car: where it is, what it is doing, how long that lasts.
  int          m_floor;
  bit          m_up, m_door, m_mov;
  int          m_door_left, m_trav_left;
  bit [NF-1:0] m_pend;
  int          stops[$];
  bit          prev_porta;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_scan();
    bit a = 1'b0;
    bit b = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i] && i > m_floor) a = 1'b1;
      if (m_pend[i] && i < m_floor) b = 1'b1;
    end
    if (m_up) return a ? 1'b1 : (b ? 1'b0 : 1'b1);
    else      return b ? 1'b0 : (a ? 1'b1 : 1'b0);
  endfunction

  task automatic model_reset();
    m_floor = 0; m_up = 1'b1; m_door = 1'b1; m_mov = 1'b0;
    m_door_left = DOOR; m_trav_left = 0; m_pend = '0;
  endtask

  task automatic model_edge(input bit [NF-1:0] c);
    bit [NF-1:0] nxt = m_pend;
    if (m_mov) begin
      nxt = nxt | c;
      if (m_trav_left > 1) m_trav_left--;
      else begin
        m_floor = m_floor + (m_up ? 1 : -1);
        if (nxt[m_floor]) begin
          nxt[m_floor] = 1'b0; m_mov = 1'b0; m_door = 1'b1; m_door_left = DOOR;
        end else m_trav_left = TRAVEL;
      end
    end else begin
      // Stationary car: own-floor call opens or holds the door, others queue.
      for (int i = 0; i < NF; i++) if (i != m_floor && c[i]) nxt[i] = 1'b1;
      if (c[m_floor]) begin
        m_door = 1'b1; m_door_left = DOOR;
      end else if (m_door && m_door_left > 1) begin
        m_door_left--;
      end else if (m_pend != 0) begin
        m_door = 1'b0; m_mov = 1'b1; m_up = model_scan(); m_trav_left = TRAVEL;
      end else begin
        m_door = 1'b0;
      end
    end
    m_pend = nxt;
  endtask

  task automatic check_all();
    check("floor",   32'(bus.floor),   32'(m_floor));
    check("porta",   32'(bus.porta),   32'(m_door));
    check("moving",  32'(bus.moving),  32'(m_mov));
    check("dir_up",  32'(bus.dir_up),  32'(m_up));
    check("pending", 32'(bus.pending), 32'(m_pend));
    if (!prev_porta && bus.porta === 1'b1) stops.push_back(int'(bus.floor));
    prev_porta = (bus.porta === 1'b1);
  endtask

  task automatic tick(input bit [NF-1:0] c);
    bus.call = c;
    @(posedge clk_2);
    model_edge(c);
    #1;
    check_all();
  endtask

  task automatic reset_tick(input bit [NF-1:0] c);
    reset    = 1'b0;
    bus.call = c;
    @(posedge clk_2);
    model_reset();
    #1;
    prev_porta = 1'b1;
    check_all();
    reset = 1'b1;
  endtask

  task automatic run_until_idle(input string tag);
    for (int i = 0; i < 60 && (m_door || m_mov || m_pend != 0); i++) tick('0);
    check(tag, 32'(!m_door && !m_mov && m_pend == 0), 32'd1);
  endtask

  function automatic int stop_at(input int k);
    return (k < stops.size()) ? stops[k] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    floor_t last_floor;
    bus.call   = '0;
    prev_porta = 1'b0;
    #2;

    // 1: reset, door dwell, then idle
    reset_tick('0);
    check("t1_floor0", 32'(bus.floor), 32'd0);
    check("t1_porta1", 32'(bus.porta), 32'd1);
    tick('0); tick('0);
    check("t1_closed", 32'(bus.porta), 32'd0);
    tick('0); tick('0); tick('0);
    check("t1_still_idle", 32'({bus.porta, bus.moving}), 32'd0);

    // 2: single call to floor 2 from idle at floor 0
    tick(4'b0100);
    check("t2_latched", 32'(bus.pending), 32'h4);
    tick('0);
    check("t2_moving", 32'(bus.moving), 32'd1);
    tick('0); tick('0);
    check("t2_floor1", 32'(bus.floor), 32'd1);
    tick('0); tick('0);
    check("t2_floor2", 32'(bus.floor), 32'd2);
    check("t2_open", 32'(bus.porta), 32'd1);
    check("t2_served", 32'(bus.pending), 32'h0);
    tick('0); tick('0);
    check("t2_door_closed", 32'(bus.porta), 32'd0);

    // 3: call behind the car while heading up from floor 1 to 3
    reset_tick('0); tick('0); tick('0);
    tick(4'b1000);
    for (int i = 0; i < 20 && m_floor != 1; i++) tick('0);
    check("t3_reach1", 32'(m_floor), 32'd1);
    stops.delete();
    tick(4'b0001);
    run_until_idle("t3_idle");
    check("t3_stop0", 32'(stop_at(0)), 32'd3);
    check("t3_stop1", 32'(stop_at(1)), 32'd0);
    check("t3_dir_down", 32'(bus.dir_up), 32'd0);

    // 4: dwell extension on the last door cycle at floor 2
    reset_tick('0); tick('0); tick('0);
    tick(4'b0100);
    for (int i = 0; i < 20 && !(m_floor == 2 && m_door && m_door_left == 1); i++) tick('0);
    check("t4_setup", 32'(m_floor == 2 && m_door && m_door_left == 1), 32'd1);
    tick(4'b0100);
    check("t4_ext_open", 32'(bus.porta), 32'd1);
    check("t4_not_latched", 32'(bus.pending), 32'h0);
    tick('0);
    check("t4_open_2", 32'(bus.porta), 32'd1);
    tick('0);
    check("t4_closed", 32'(bus.porta), 32'd0);

    // 5: simultaneous calls above and below, idle at floor 1 heading up
    reset_tick('0); tick('0); tick('0);
    tick(4'b0010);
    run_until_idle("t5_at1");
    last_floor = bus.floor;
    check("t5_floor1", 32'(last_floor), 32'd1);
    check("t5_dir_up", 32'(bus.dir_up), 32'd1);
    stops.delete();
    tick(4'b1001);
    run_until_idle("t5_idle");
    check("t5_stop0", 32'(stop_at(0)), 32'd3);
    check("t5_stop1", 32'(stop_at(1)), 32'd0);

    // 6: reset mid-travel between floors 2 and 3
    reset_tick('0); tick('0); tick('0);
    tick(4'b1000);
    for (int i = 0; i < 20 && !(m_floor == 2 && m_mov); i++) tick('0);
    check("t6_setup", 32'(m_floor == 2 && m_mov), 32'd1);
    tick(4'b0001);
    check("t6_pending", 32'(bus.pending), 32'h9);
    reset_tick('0);
    check("t6_floor", 32'(bus.floor), 32'd0);
    check("t6_porta", 32'(bus.porta), 32'd1);
    check("t6_moving", 32'(bus.moving), 32'd0);
    check("t6_pend", 32'(bus.pending), 32'h0);
    check("t6_dir", 32'(bus.dir_up), 32'd1);

    // Random calls with occasional resets
    for (int i = 0; i < 500; i++) begin
      bit [NF-1:0] c;
      c = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
      if ($urandom_range(0, 99) == 0) reset_tick(c);
      else                            tick(c);
    end
    run_until_idle("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
